// File: rtl/uart_link_pkg.sv
// Shared types and helpers for the UART symbol link.
// UART_PARITY_EN adds one even-parity bit to every frame.
package uart_link_pkg;

`ifdef UART_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Frame length for the default 8 data bits: start + data + parity + stop.
  localparam int unsigned FRAME_BITS = 1 + 8 + PARITY_BITS + 1;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_t;
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_t;

  // Buckets d-1 (mod 2^dec_bits) by its top sym_bits bits, so 0 lands in the last bucket.
  function automatic logic [15:0] sym_decode(input logic [15:0] d,
                                             input int unsigned dec_bits,
                                             input int unsigned sym_bits);
    logic [15:0] mask;
    logic [15:0] t;
    mask = 16'((32'd1 << dec_bits) - 32'd1);
    t    = (d - 16'd1) & mask;
    return t >> (dec_bits - sym_bits);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO without a pop is dropped and flagged.
module sync_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       valid_o,
  output logic [$clog2(Depth+1)-1:0] level_o,
  output logic                       overrun_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             overrun_q;
  logic             full, do_push, do_pop;

  assign full    = (level_q == LvlW'(Depth));
  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_i && !do_push;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LvlW'(do_push) - LvlW'(do_pop);
    end
  end

  assign valid_o   = (level_q != '0);
  assign rdata_o   = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o   = level_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_symbol_link.sv
// UART transceiver: RX frames are decoded to symbols and queued in a FWFT FIFO.
// Define UART_PARITY_EN for an even-parity bit on both directions.
module uart_symbol_link
  import uart_link_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned DEC_BITS   = 4,
  parameter int unsigned SYM_BITS   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  output logic                            tx,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            tx_busy,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic [SYM_BITS-1:0]             rx_sym,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_level,
  output logic                            frame_err,
  output logic                            overrun,
  output logic                            parity_err
);
  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_DIV / 2 - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_BITS - 1);

  // ---------------- TX ----------------
  tx_state_t            tx_state_q;
  logic [CntW-1:0]      tx_cnt_q;
  logic [BitW-1:0]      tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_q;
  logic                 tx_baud_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  assign tx_baud_end = (tx_cnt_q == BaudLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_cnt_q <= (tx_state_q == TxIdle || tx_baud_end) ? '0 : tx_cnt_q + 1'b1;
      unique case (tx_state_q)
        TxIdle: if (tx_valid) begin
          tx_shift_q <= tx_data;
          tx_q       <= 1'b0;
          tx_state_q <= TxStart;
`ifdef UART_PARITY_EN
          tx_par_q   <= ^tx_data;
`endif
        end
        TxStart: if (tx_baud_end) begin
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= tx_shift_q >> 1;
          tx_bit_q   <= '0;
          tx_state_q <= TxData;
        end
        TxData: if (tx_baud_end) begin
          if (tx_bit_q == BitLast) begin
`ifdef UART_PARITY_EN
            tx_q       <= tx_par_q;
            tx_state_q <= TxParity;
`else
            tx_q       <= 1'b1;
            tx_state_q <= TxStop;
`endif
          end else begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= tx_bit_q + 1'b1;
          end
        end
        TxParity: if (tx_baud_end) begin
          tx_q       <= 1'b1;
          tx_state_q <= TxStop;
        end
        TxStop: if (tx_baud_end) tx_state_q <= TxIdle;
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (tx_state_q == TxIdle);
  assign tx_busy  = (tx_state_q != TxIdle);

  // ---------------- RX ----------------
  rx_state_t            rx_state_q;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CntW-1:0]      rx_cnt_q;
  logic [BitW-1:0]      rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 push_q, frame_err_q;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, parity_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= RxIdle;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      rx_cnt_q    <= rx_cnt_q + 1'b1;
`ifdef UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      unique case (rx_state_q)
        RxIdle: begin
          rx_cnt_q <= '0;
          if (rx_prev_q && !rx_s2_q) rx_state_q <= RxStart;
        end
        // A line already back high at mid start bit is treated as a glitch.
        RxStart: if (rx_cnt_q == HalfLast) begin
          rx_cnt_q   <= '0;
          rx_bit_q   <= '0;
          rx_state_q <= rx_s2_q ? RxIdle : RxData;
        end
        RxData: if (rx_cnt_q == BaudLast) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_q   <= rx_bit_q + 1'b1;
          if (rx_bit_q == BitLast) begin
`ifdef UART_PARITY_EN
            rx_state_q <= RxParity;
`else
            rx_state_q <= RxStop;
`endif
          end
        end
        RxParity: if (rx_cnt_q == BaudLast) begin
          rx_cnt_q   <= '0;
`ifdef UART_PARITY_EN
          rx_par_q   <= rx_s2_q;
`endif
          rx_state_q <= RxStop;
        end
        RxStop: if (rx_cnt_q == BaudLast) begin
          rx_state_q <= RxIdle;
          if (!rx_s2_q) frame_err_q <= 1'b1;
`ifdef UART_PARITY_EN
          else if ((^rx_shift_q) != rx_par_q) parity_err_q <= 1'b1;
`endif
          else push_q <= 1'b1;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  logic [15:0] sym_full;
  logic        sym_unused;
  assign sym_full   = sym_decode(16'(rx_shift_q), DEC_BITS, SYM_BITS);
  assign sym_unused = ^sym_full[15:SYM_BITS];

  logic [DATA_BITS+SYM_BITS-1:0] fifo_rdata;

  sync_fifo #(
    .Width(DATA_BITS + SYM_BITS),
    .Depth(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .push_i   (push_q),
    .wdata_i  ({rx_shift_q, sym_full[SYM_BITS-1:0]}),
    .pop_i    (rx_ready),
    .rdata_o  (fifo_rdata),
    .valid_o  (rx_valid),
    .level_o  (rx_level),
    .overrun_o(overrun)
  );

  assign rx_data   = fifo_rdata[DATA_BITS+SYM_BITS-1:SYM_BITS];
  assign rx_sym    = fifo_rdata[SYM_BITS-1:0];
  assign frame_err = frame_err_q;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_symbol_link.sv
// Directed bench for uart_symbol_link at BAUD_DIV=16: TX frame timing, RX decode, overrun, reset.
module tb_uart_symbol_link;
  import uart_link_pkg::*;

  localparam int unsigned BAUD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy;
  logic [7:0] rx_data;
  logic [1:0] rx_sym;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [2:0] rx_level;
  logic       frame_err, overrun, parity_err;

  uart_symbol_link #(
    .DATA_BITS (8),
    .BAUD_DIV  (BAUD),
    .DEC_BITS  (4),
    .SYM_BITS  (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .tx        (tx),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .rx_data   (rx_data),
    .rx_sym    (rx_sym),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_level  (rx_level),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Popped {data, sym} words and flag pulse counts, observed away from the clock edge.
  logic [9:0] popped[$];
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int perr_cnt = 0;
  int max_lvl  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) popped.push_back({rx_data, rx_sym});
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (parity_err) perr_cnt <= perr_cnt + 1;
      if (int'(rx_level) > max_lvl) max_lvl <= int'(rx_level);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_bit(input logic v);
    rx = v;
    step(BAUD);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
    if (PARITY_BITS != 0) rx_bit(^d);
    rx_bit(stop);
    rx = 1'b1;
    step(2 * BAUD);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [1:0] sym;
    logic       ferr;
  } rx_vec_t;

  rx_vec_t    vecs[9];
  logic [9:0] word;
  logic [FRAME_BITS-1:0] exp_bits;
  int         ferr_before;

  initial begin
    vecs[0] = '{data: 8'h37, stop: 1'b1, sym: 2'b01, ferr: 1'b0};
    vecs[1] = '{data: 8'h30, stop: 1'b1, sym: 2'b11, ferr: 1'b0};
    vecs[2] = '{data: 8'h55, stop: 1'b0, sym: 2'b00, ferr: 1'b1};
    vecs[3] = '{data: 8'h12, stop: 1'b1, sym: 2'b00, ferr: 1'b0};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, sym: 2'b11, ferr: 1'b0};
    vecs[5] = '{data: 8'h08, stop: 1'b1, sym: 2'b01, ferr: 1'b0};
    vecs[6] = '{data: 8'h0D, stop: 1'b1, sym: 2'b11, ferr: 1'b0};
    vecs[7] = '{data: 8'h04, stop: 1'b1, sym: 2'b00, ferr: 1'b0};
    vecs[8] = '{data: 8'h05, stop: 1'b1, sym: 2'b01, ferr: 1'b0};

    // Reset state.
    #12;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_level", 32'(rx_level), 32'd0);
    check("rst_rx_data", 32'({rx_data, rx_sym}), 32'd0);
    check("rst_flags", 32'({frame_err, overrun, parity_err}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(3);

    // TX 0xA5: start bit the cycle after accept, BAUD cycles per bit.
    exp_bits = '0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = tx_data_a5(i);
    if (PARITY_BITS != 0) exp_bits[9] = ^8'hA5;
    exp_bits[FRAME_BITS-1] = 1'b1;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    for (int b = 0; b < int'(FRAME_BITS); b++) begin
      for (int c = 0; c < int'(BAUD); c++) begin
        @(negedge clk);
        if (c == 0 || c == int'(BAUD) - 1) check($sformatf("tx_bit%0d_c%0d", b, c),
                                                 32'(tx), 32'(exp_bits[b]));
        if (b == 0 && c == 0) check("tx_busy_start", 32'({tx_busy, tx_ready}), 32'b10);
      end
    end
    check("tx_ready_last_stop", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("tx_ready_after", 32'({tx_ready, tx_busy, tx}), 32'b101);
    @(posedge clk);
    #1;

    // Table-driven RX frames with rx_ready held high.
    rx_ready = 1'b1;
    max_lvl  = 0;
    for (int v = 0; v < 9; v++) begin
      ferr_before = ferr_cnt;
      send_rx(vecs[v].data, vecs[v].stop);
      check($sformatf("rx%0d_ferr", v), 32'(ferr_cnt - ferr_before), 32'(vecs[v].ferr));
      check($sformatf("rx%0d_count", v), 32'(popped.size()), vecs[v].ferr ? 32'd0 : 32'd1);
      check($sformatf("rx%0d_valid", v), 32'(rx_valid), 32'd0);
      if (popped.size() > 0) begin
        word = popped.pop_front();
        check($sformatf("rx%0d_data", v), 32'(word[9:2]), 32'(vecs[v].data));
        check($sformatf("rx%0d_sym", v), 32'(word[1:0]), 32'(vecs[v].sym));
      end
    end
    check("rx_max_level", 32'(max_lvl), 32'd1);

    // Start-bit glitch: 6 low cycles, then a real frame 0x9C.
    ferr_before = ferr_cnt;
    rx = 1'b0;
    step(6);
    rx = 1'b1;
    step(3 * BAUD);
    check("glitch_no_push", 32'(popped.size()), 32'd0);
    check("glitch_no_flag", 32'(ferr_cnt - ferr_before + perr_cnt), 32'd0);
    send_rx(8'h9C, 1'b1);
    check("glitch_next_count", 32'(popped.size()), 32'd1);
    if (popped.size() > 0) begin
      word = popped.pop_front();
      check("glitch_next_word", 32'(word), 32'({8'h9C, 2'b10}));
    end

    // Overrun: 5 frames into a 4-deep FIFO with no drain.
    rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_rx(8'(i), 1'b1);
    check("ovr_level4", 32'(rx_level), 32'd4);
    check("ovr_none_yet", 32'(ovr_cnt), 32'd0);
    check("ovr_head", 32'({rx_valid, rx_data, rx_sym}), 32'({1'b1, 8'h01, 2'b00}));
    send_rx(8'h05, 1'b1);
    check("ovr_level_still4", 32'(rx_level), 32'd4);
    check("ovr_pulse", 32'(ovr_cnt), 32'd1);
    rx_ready = 1'b1;
    step(10);
    rx_ready = 1'b0;
    check("drain_count", 32'(popped.size()), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      if (popped.size() > 0) begin
        word = popped.pop_front();
        check($sformatf("drain_%0d", i), 32'(word), 32'({8'(i), i == 4 ? 2'b00 : 2'b00}));
      end
    end
    check("drain_empty", 32'({rx_valid, rx_level}), 32'd0);

    // Reset in the middle of a TX frame with a byte parked in the FIFO.
    send_rx(8'h42, 1'b1);
    check("pre_rst_level", 32'(rx_level), 32'd1);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    step(4 * BAUD + BAUD / 2);
    check("pre_rst_busy", 32'(tx_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'({tx, tx_ready, tx_busy}), 32'b110);
    check("mid_rst_rx", 32'({rx_valid, rx_level, rx_data, rx_sym}), 32'd0);
    step(3);
    rst_n = 1'b1;
    ferr_before = ferr_cnt + ovr_cnt + perr_cnt;
    step(2 * BAUD);
    check("post_rst_tx", 32'({tx, tx_ready, tx_busy}), 32'b110);
    check("post_rst_level", 32'(rx_level), 32'd0);
    check("post_rst_flags", 32'(ferr_cnt + ovr_cnt + perr_cnt - ferr_before), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic tx_data_a5(input int i);
    logic [7:0] a5;
    a5 = 8'hA5;
    return a5[i];
  endfunction

endmodule
